// File: rtl/branch_tag_alloc_pkg.sv
// rtl/branch_tag_alloc_pkg.sv - shared constants and types for the branch checkpoint tag allocator
package branch_tag_alloc_pkg;

    localparam int BHT_NUM_TAGS    = 4;
    localparam int BHT_TAG_W       = 2;
    localparam int BHT_RECOVER_CYC = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } bta_state_t;

    typedef logic [BHT_TAG_W-1:0] brtag_t;

endpackage

// File: rtl/branch_tag_alloc_slot_grant_scan.sv
// rtl/branch_tag_alloc_slot_grant_scan.sv - in-order grant scan over the four fetch slots
module slot_grant_scan
    import branch_tag_alloc_pkg::*;
#(
    parameter int TAG_W = BHT_TAG_W
) (
    input  logic [3:0]         alloc_vld,
    input  logic [TAG_W:0]     free_cnt,
    output logic [3:0]         gnt,
    output logic [4*TAG_W-1:0] offsets,
    output logic               refused,
    output logic [1:0]         hold_idx,
    output logic [TAG_W:0]     gnt_cnt
);

    logic [2:0] cnt;
    logic [3:0] free_ext;

    assign free_ext = 4'(free_cnt);

    // Slot 3 is oldest; the first refusal blocks every younger slot.
    always_comb begin
        gnt      = '0;
        offsets  = '0;
        refused  = 1'b0;
        hold_idx = 2'd0;
        cnt      = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            offsets[i*TAG_W +: TAG_W] = cnt[TAG_W-1:0];
            if (alloc_vld[i] && !refused) begin
                if ({1'b0, cnt} < free_ext) begin
                    gnt[i] = 1'b1;
                    cnt    = cnt + 3'd1;
                end else begin
                    refused  = 1'b1;
                    hold_idx = 2'(3 - i);
                end
            end
        end
        gnt_cnt = (TAG_W+1)'(cnt);
    end

endmodule

// File: rtl/branch_tag_alloc.sv
// rtl/branch_tag_alloc.sv - in-order branch checkpoint tag allocator with mispredict recovery
module branch_tag_alloc
    import branch_tag_alloc_pkg::*;
#(
    parameter int NUM_TAGS    = BHT_NUM_TAGS,
    parameter int TAG_W       = BHT_TAG_W,
    parameter int RECOVER_CYC = BHT_RECOVER_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          alloc_vld,
    output logic [3:0]          alloc_gnt,
    output logic [4*TAG_W-1:0]  alloc_tags,
    output logic                stall_fetch_o,
    output logic [1:0]          hold_slot,
    input  logic                cmt_vld,
    input  logic                cmt_mispred,
    output logic                squash_vld,
    output logic [NUM_TAGS-1:0] squash_mask,
    output logic [NUM_TAGS-1:0] live_mask,
    output logic [TAG_W:0]      tag_cnt,
    output logic                tags_full,
    output logic                underflow_err
);

    localparam logic [TAG_W:0]      FULL_CNT  = (TAG_W+1)'(NUM_TAGS);
    localparam logic [TAG_W:0]      CNT_ONE   = 1;
    localparam logic [TAG_W-1:0]    TAG_ONE   = 1;
    localparam logic [NUM_TAGS-1:0] LSB_ONE   = 1;
    localparam logic [3:0]          RCNT_INIT = 4'(RECOVER_CYC - 1);

    bta_state_t           state, state_nxt;
    logic [TAG_W-1:0]     head, tail;
    logic [3:0]           rcnt;
    logic                 in_recover;
    logic [TAG_W:0]       free_cnt;
    logic [3:0]           scan_vld;
    logic [4*TAG_W-1:0]   offsets;
    logic                 refused;
    logic [TAG_W:0]       gnt_cnt;
    logic                 cmt_empty, mispred_cmt, do_squash, do_commit;
    logic [NUM_TAGS-1:0]  head_bit, new_live;
    logic [TAG_W:0]       cnt_after_cmt;

    assign free_cnt    = FULL_CNT - tag_cnt;
    assign cmt_empty   = cmt_vld & (tag_cnt == '0);
    assign mispred_cmt = cmt_vld & cmt_mispred;
    assign do_squash   = mispred_cmt & ~cmt_empty;
    assign do_commit   = cmt_vld & ~cmt_mispred & ~cmt_empty;
    assign head_bit    = LSB_ONE << head;
    assign tags_full   = (tag_cnt == FULL_CNT);

    // Nothing may be granted during reset, recovery or a mispredicting commit.
    assign scan_vld = (rst_n && !in_recover && !mispred_cmt) ? alloc_vld : 4'b0000;

    slot_grant_scan #(.TAG_W(TAG_W)) u_scan (
        .alloc_vld (scan_vld),
        .free_cnt  (free_cnt),
        .gnt       (alloc_gnt),
        .offsets   (offsets),
        .refused   (refused),
        .hold_idx  (hold_slot),
        .gnt_cnt   (gnt_cnt)
    );

    assign stall_fetch_o = rst_n & (in_recover | refused | mispred_cmt);

    always_comb begin
        alloc_tags = '0;
        new_live   = '0;
        for (int i = 0; i < 4; i++) begin
            if (alloc_gnt[i]) begin
                alloc_tags[i*TAG_W +: TAG_W] = tail + offsets[i*TAG_W +: TAG_W];
                new_live[tail + offsets[i*TAG_W +: TAG_W]] = 1'b1;
            end
        end
    end

    assign cnt_after_cmt = do_commit ? tag_cnt - CNT_ONE : tag_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            tag_cnt       <= '0;
            live_mask     <= '0;
            squash_vld    <= 1'b0;
            squash_mask   <= '0;
            underflow_err <= 1'b0;
            rcnt          <= 4'd0;
        end else begin
            squash_vld  <= do_squash;
            squash_mask <= do_squash ? (live_mask & ~head_bit) : '0;
            if (cmt_empty) begin
                underflow_err <= 1'b1;
            end
            if (do_squash) begin
                head      <= head + TAG_ONE;
                tail      <= head + TAG_ONE;
                tag_cnt   <= '0;
                live_mask <= '0;
            end else begin
                if (do_commit) begin
                    head <= head + TAG_ONE;
                end
                tail      <= tail + gnt_cnt[TAG_W-1:0];
                tag_cnt   <= cnt_after_cmt + gnt_cnt;
                live_mask <= (live_mask & ~(do_commit ? head_bit : '0)) | new_live;
            end
            if (do_squash) begin
                rcnt <= RCNT_INIT;
            end else if (in_recover && rcnt != 4'd0) begin
                rcnt <= rcnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_squash) state_nxt = RECOVER;
            RECOVER: if (rcnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_recover = (state == RECOVER);
    end

endmodule
